uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

Parametrised UART transmitter: the next generation of the fixed 8N1, 50 MHz/115200 transmitter. It serialises one word per request with configurable baud divisor, data width, stop-bit count and optional parity, and exposes a busy/done handshake so an upstream FIFO or command sequencer can stream frames back-to-back. It sits between the byte source and the `tx_pin` pad.

## Interface
- `CLKS_PER_BIT`, 434: clock cycles per bit (434 = 50 MHz/115200, 5208 = 50 MHz/9600). Legal range is ≥ 2.
- `DATA_BITS`, 8: data bits per frame. Legal range is 5..9.
- `STOP_BITS`, 1: stop bits per frame. Legal values are 1 or 2.

- `clk`  in  1: system clock. Single clock domain.
- `rst_n`  in  1: asynchronous, active-low reset.
- `tx_en_sig`  in  1: send request. It is sampled only in IDLE.
- `tx_data`  in  DATA_BITS: word to send. Captured on the accept cycle.
- `parity_odd`  in  1: 1 selects odd parity, 0 selects even. It is sampled on the accept cycle and ignored without `UART_TX_PARITY_EN`.
- `tx_busy`  out  1: a frame is in progress.
- `tx_done_sig`  out  1: one-cycle pulse when a frame completes.
- `tx_pin`  out  1: serial line. Idles high.

## Operation
- Reset values:
  - `tx_pin` = 1, `tx_busy` = 0, `tx_done_sig` = 0.
  - FSM = IDLE, bit-timer = 0, bit index = 0, shift register = 0.
- FSM states are IDLE, START, DATA, PARITY, STOP.
  - IDLE to START: `tx_en_sig` = 1 in IDLE (the accept cycle). Latch `tx_data` (and parity) into the shift register, drive `tx_pin` = 0, set `tx_busy` = 1.
  - START to DATA: after CLKS_PER_BIT cycles.
  - DATA: send data LSB first, one bit per CLKS_PER_BIT cycles. After bit DATA_BITS-1, go to PARITY (if enabled) or to STOP.
  - PARITY to STOP: after CLKS_PER_BIT cycles.
  - STOP: hold `tx_pin` = 1 for STOP_BITS×CLKS_PER_BIT cycles, then go to IDLE. On that transition set `tx_busy` = 0 and pulse `tx_done_sig` for one cycle.
- Bit-timer width is $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary. It never overflows.
- Bit-index width is $clog2(DATA_BITS+1).
- `tx_en_sig` while busy is ignored. It is neither queued nor does it corrupt the frame in flight.
- `tx_data` and `parity_odd` may change freely after the accept cycle.
- Reset mid-frame aborts the frame:
  - `tx_pin` returns to 1 immediately (asynchronous).
  - No `tx_done_sig` is generated.
- All outputs are registered. No combinational path from input to output.

## Timing
- N = 1 + DATA_BITS + P + STOP_BITS, where P = 1 if parity is compiled in, else 0.
- Let T be the accept cycle.
- Start bit: `tx_pin` = 0 from T+1 through T+CLKS_PER_BIT.
- Bit k (0-based within the frame) occupies cycles T+1+k·CLKS_PER_BIT through T+(k+1)·CLKS_PER_BIT.
- `tx_busy` is high from T+1 through T+N·CLKS_PER_BIT.
- `tx_done_sig` is high in exactly cycle T+N·CLKS_PER_BIT+1. That is also the first IDLE cycle, with `tx_busy` = 0.
- `tx_en_sig` high in the done cycle is accepted. The next start bit then begins one cycle later.
- Minimum frame-to-frame period is N·CLKS_PER_BIT+1 cycles, i.e. one extra idle-high cycle between frames.
- Request-to-line latency is 1 cycle.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - The PARITY state is compiled in, and one parity bit is inserted after the data bits.
  - Even parity (`parity_odd` = 0) sends ^data. Odd parity (`parity_odd` = 1) sends ~^data.
  - N includes the parity bit.
- Not defined:
  - PARITY logic is removed and the FSM goes DATA to STOP.
  - `parity_odd` is unconnected internally.
  - Frame length is 1+DATA_BITS+STOP_BITS bits.

## Test plan
All scenarios use CLKS_PER_BIT = 4.

- 8N1, no macro, `tx_data` = 0x55 accepted at T → `tx_pin` sampled mid-bit reads 0,1,0,1,0,1,0,1,0,1. `tx_busy` is high for T+1..T+40. `tx_done_sig` pulses only at T+41.
- With `UART_TX_PARITY_EN`, `tx_data` = 0x07:
  - `parity_odd` = 0 → parity bit (cycles T+37..T+40) = 1.
  - `parity_odd` = 1 → parity bit = 0.
  - In both cases `tx_done_sig` pulses at T+45.
- `tx_en_sig` held high continuously with data 0xA3 then 0x3C:
  - Second start bit begins at T+42. Exactly one idle-high cycle (T+41) separates the frames.
  - Second frame bits match 0x3C LSB first.
- Pulse `tx_en_sig` with 0xFF at T+10 while busy with 0x00 → frame stays 0x00 (`tx_pin` low T+1..T+36). Only one `tx_done_sig` pulse occurs.
- Assert `rst_n` = 0 at T+15 mid-data → `tx_pin` = 1, `tx_busy` = 0 immediately. No `tx_done_sig` pulse. After release, a new 0x81 request produces a correct full frame.
- DATA_BITS = 7, STOP_BITS = 2, no macro, `tx_data` = 0x41 → 10-bit frame of 40 cycles. Stop high T+33..T+40. `tx_done_sig` pulses at T+41.

Source files
------------

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter sending a start bit, DATA_BITS data bits LSB first,
// an optional parity bit (macro UART_TX_PARITY_EN) and STOP_BITS stop bits, with busy/done.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_en_sig,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 parity_odd,
  output logic                 tx_busy,
  output logic                 tx_done_sig,
  output logic                 tx_pin
);

  localparam int TIMER_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W   = $clog2(DATA_BITS + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
  localparam logic [IDX_W-1:0]   DATA_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0]   STOP_LAST  = IDX_W'(STOP_BITS - 1);
  localparam logic [IDX_W-1:0]   IDX_ONE    = IDX_W'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t               state_r, state_s;
  logic [TIMER_W-1:0]   timer_r, timer_s;
  logic [IDX_W-1:0]     idx_r, idx_s;
  logic [DATA_BITS-1:0] shift_r, shift_s;
  logic                 pin_s, busy_s, done_s, bit_end_s;

`ifdef UART_TX_PARITY_EN
  logic parity_r, parity_s;

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction
`else
  logic unused_parity_odd_s;
  assign unused_parity_odd_s = parity_odd;
`endif

  // Next-state, datapath and next-output logic; outputs are registered below.
  always_comb begin
    state_s   = state_r;
    timer_s   = {TIMER_W{1'b0}};
    idx_s     = idx_r;
    shift_s   = shift_r;
    pin_s     = tx_pin;
    busy_s    = tx_busy;
    done_s    = 1'b0;
    bit_end_s = (timer_r == TIMER_LAST);
`ifdef UART_TX_PARITY_EN
    parity_s  = parity_r;
`endif
    if ((state_r != IDLE) && !bit_end_s) begin
      timer_s = timer_r + TIMER_ONE;
    end else begin
      timer_s = {TIMER_W{1'b0}};
    end

    case (state_r)
      IDLE: begin
        pin_s  = 1'b1;
        busy_s = 1'b0;
        if (tx_en_sig) begin
          state_s  = START;
          shift_s  = tx_data;
          idx_s    = {IDX_W{1'b0}};
          pin_s    = 1'b0;
          busy_s   = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_s = parity_bit(tx_data, parity_odd);
`endif
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_s = DATA;
          idx_s   = {IDX_W{1'b0}};
          pin_s   = shift_r[0];
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          if (idx_r == DATA_LAST) begin
            idx_s   = {IDX_W{1'b0}};
`ifdef UART_TX_PARITY_EN
            state_s = PARITY;
            pin_s   = parity_r;
`else
            state_s = STOP;
            pin_s   = 1'b1;
`endif
          end else begin
            // Bit 0 is already on the line, so the next bit is shift_r[1].
            idx_s   = idx_r + IDX_ONE;
            shift_s = {1'b0, shift_r[DATA_BITS-1:1]};
            pin_s   = shift_r[1];
          end
        end else begin
          state_s = DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end_s) begin
          state_s = STOP;
          idx_s   = {IDX_W{1'b0}};
          pin_s   = 1'b1;
        end else begin
          state_s = PARITY;
        end
      end
`endif
      STOP: begin
        if (bit_end_s) begin
          if (idx_r == STOP_LAST) begin
            state_s = IDLE;
            idx_s   = {IDX_W{1'b0}};
            pin_s   = 1'b1;
            busy_s  = 1'b0;
            done_s  = 1'b1;
          end else begin
            idx_s   = idx_r + IDX_ONE;
          end
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s = IDLE;
        idx_s   = {IDX_W{1'b0}};
        pin_s   = 1'b1;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; reset forces the line idle at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      timer_r     <= {TIMER_W{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      shift_r     <= {DATA_BITS{1'b0}};
      tx_pin      <= 1'b1;
      tx_busy     <= 1'b0;
      tx_done_sig <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_r    <= 1'b0;
`endif
    end else begin
      state_r     <= state_s;
      timer_r     <= timer_s;
      idx_r       <= idx_s;
      shift_r     <= shift_s;
      tx_pin      <= pin_s;
      tx_busy     <= busy_s;
      tx_done_sig <= done_s;
`ifdef UART_TX_PARITY_EN
      parity_r    <= parity_s;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: an 8N1 and a 7-data/2-stop instance (equal frame length) share
// stimulus; each has its own reference model queue and a monitor scoring every frame.
module tb_uart_tx_frame;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NC = (1 + 8 + P + 1) * C;

  typedef struct {
    logic [8:0] data;
    logic       podd;
    int         t;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_en_sig;
  logic [8:0] tx_data;
  logic       parity_odd;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  // Cycle index: during a cycle, posedge processes see the index of the cycle just ending.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int DB = (g == 0) ? 8 : 7;
    localparam int SB = (g == 0) ? 1 : 2;
    localparam int NB = 1 + DB + P + SB;

    logic   pin, busy, done;
    exp_t   exp_q[$];
    logic   cap[$];
    int     free_cyc = 0;
    int     s_cyc = 0;
    logic   in_frame = 1'b0;

    uart_tx_frame #(.CLKS_PER_BIT(C), .DATA_BITS(DB), .STOP_BITS(SB)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tx_en_sig  (tx_en_sig),
      .tx_data    (tx_data[DB-1:0]),
      .parity_odd (parity_odd),
      .tx_busy    (busy),
      .tx_done_sig(done),
      .tx_pin     (pin)
    );

    // Frame bit b: start 0, data LSB first, optional parity, then stop ones.
    function automatic logic exp_bit(input exp_t e, input int b);
      if (b == 0) return 1'b0;
      if (b <= DB) return e.data[b-1];
      if ((P == 1) && (b == DB + 1)) return (($countones(e.data) % 2) == 1) ^ e.podd;
      return 1'b1;
    endfunction

    // Reference model: a request is taken whenever the previous frame is over.
    always @(posedge clk) begin
      if (!rst_n) begin
        exp_q.delete();
        free_cyc <= 0;
      end else if (tx_en_sig && (cyc >= free_cyc)) begin
        exp_q.push_back('{data: 9'(tx_data[DB-1:0]), podd: parity_odd, t: cyc});
        free_cyc <= cyc + NB * C + 1;
      end
    end

    // Monitor: captures the line while busy and scores the frame on the done pulse.
    always @(negedge clk) begin
      exp_t       e;
      logic [15:0] obs, want;
      int         unstable;
      if (!rst_n) begin
        in_frame <= 1'b0;
        cap.delete();
      end else if (done) begin
        check($sformatf("u%0d.done_busy", g), 32'(busy), 32'd0);
        check($sformatf("u%0d.done_pin", g), 32'(pin), 32'd1);
        check($sformatf("u%0d.done_expected", g), 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check($sformatf("u%0d.start_cycle", g), 32'(s_cyc), 32'(e.t + 1));
          check($sformatf("u%0d.done_cycle", g), 32'(cyc), 32'(e.t + NB * C + 1));
          check($sformatf("u%0d.frame_len", g), 32'(cap.size()), 32'(NB * C));
          if (cap.size() == NB * C) begin
            obs = 16'h0000;
            want = 16'h0000;
            unstable = 0;
            for (int b = 0; b < NB; b++) begin
              obs[b]  = cap[b * C + C / 2];
              want[b] = exp_bit(e, b);
            end
            for (int j = 0; j < NB * C; j++) begin
              if (cap[j] !== cap[(j / C) * C + C / 2]) unstable++;
            end
            check($sformatf("u%0d.frame_bits(data %0h)", g, e.data), 32'(obs), 32'(want));
            check($sformatf("u%0d.bit_stable", g), 32'(unstable), 32'd0);
          end
        end
        in_frame <= 1'b0;
        cap.delete();
      end else if (busy) begin
        if (!in_frame) begin
          in_frame <= 1'b1;
          s_cyc <= cyc;
        end
        cap.push_back(pin);
      end else if (in_frame) begin
        check($sformatf("u%0d.busy_held", g), 32'(busy), 32'd1);
        in_frame <= 1'b0;
        cap.delete();
      end else begin
        check($sformatf("u%0d.idle_pin", g), 32'(pin), 32'd1);
      end
    end
  end

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic req(input logic [8:0] d, input logic po);
    @(negedge clk);
    tx_en_sig  = 1'b1;
    tx_data    = d;
    parity_odd = po;
    @(negedge clk);
    tx_en_sig  = 1'b0;
    tx_data    = 9'($urandom);
    parity_odd = 1'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".u0_pin"}, 32'(u[0].pin), 32'd1);
    check({tag, ".u0_busy"}, 32'(u[0].busy), 32'd0);
    check({tag, ".u0_done"}, 32'(u[0].done), 32'd0);
    check({tag, ".u1_pin"}, 32'(u[1].pin), 32'd1);
    check({tag, ".u1_busy"}, 32'(u[1].busy), 32'd0);
    check({tag, ".u1_done"}, 32'(u[1].done), 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    tx_en_sig  = 1'b0;
    tx_data    = 9'h000;
    parity_odd = 1'b0;
    idle(3);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle(2);

    req(9'h055, 1'b0);
    idle(NC + 2);

    // Second request lands exactly in the done cycle of the first.
    req(9'h007, 1'b0);
    idle(NC - 1);
    req(9'h007, 1'b1);
    idle(NC + 2);

    // Request held high across two frames; data switches after the first accept.
    @(negedge clk);
    tx_en_sig = 1'b1;
    tx_data   = 9'h0A3;
    @(negedge clk);
    tx_data   = 9'h03C;
    idle(NC + 1);
    tx_en_sig = 1'b0;
    idle(NC + 2);

    // Request at T+10 while busy must be dropped.
    req(9'h000, 1'b0);
    idle(8);
    req(9'h0FF, 1'b0);
    idle(NC);

    // Reset at T+15 aborts the frame; a fresh frame follows.
    req(9'h05A, 1'b0);
    idle(13);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midframe_reset");
    idle(3);
    rst_n = 1'b1;
    idle(2);
    req(9'h081, 1'b0);
    idle(NC + 2);

    for (int i = 0; i < 24; i++) begin
      req(9'($urandom), 1'($urandom));
      idle(NC - 3 + $urandom_range(0, 4));
    end
    idle(NC + 4);

    check("u0.queue_drained", 32'(u[0].exp_q.size()), 32'd0);
    check("u1.queue_drained", 32'(u[1].exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
